// File: rtl/pusher_chain.sv
// Elastic DEPTH-stage, WIDTH-bit delay line with valid/ready backpressure and flush.
// Optional registered occupancy port `count` when PUSHER_CHAIN_COUNT_EN is defined.
module pusher_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PUSHER_CHAIN_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            v_d;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic                        accept;

    // A stage is blocked only if every stage downstream is full and the
    // consumer stalls; walking from the output end avoids a comb loop.
    always_comb begin : adv_calc
        logic blocked;
        blocked = ~out_ready;
        adv     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i]  = v_q[i] & ~blocked;
            blocked = blocked & v_q[i];
        end
    end

    assign in_ready  = ~reset & (~v_q[0] | adv[0]);
    assign accept    = in_valid & in_ready;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (accept) begin
            v_d[0]    = 1'b1;
            data_d[0] = in_data;
        end else if (adv[0]) begin
            v_d[0] = 1'b0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
                v_d[i]    = 1'b1;
                data_d[i] = data_q[i-1];
            end else if (adv[i]) begin
                v_d[i] = 1'b0;
            end
        end
        // Flush wins over any accept in the same cycle.
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q    <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

`ifdef PUSHER_CHAIN_COUNT_EN
    logic                        emit;
    logic [$clog2(DEPTH+1)-1:0] count_q;
    logic [$clog2(DEPTH+1)-1:0] count_d;

    assign emit  = adv[DEPTH-1];
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({accept, emit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

endmodule

// File: tb/tb_pusher_chain.sv
// Directed bench for pusher_chain: 8x8 chain plus a DEPTH=1, WIDTH=16 instance.
module tb_pusher_chain;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    logic        s_flush;
    logic        s_in_valid;
    logic [15:0] s_in_data;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_data;
    logic        s_out_ready;

`ifdef PUSHER_CHAIN_COUNT_EN
    logic [3:0]  count;
    logic [0:0]  s_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pusher_chain #(.WIDTH(8), .DEPTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PUSHER_CHAIN_COUNT_EN
        ,
        .count     (count)
`endif
    );

    pusher_chain #(.WIDTH(16), .DEPTH(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready)
`ifdef PUSHER_CHAIN_COUNT_EN
        ,
        .count     (s_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef PUSHER_CHAIN_COUNT_EN
        chk(tag, 32'(count), 32'(exp));
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic sdrive(input logic iv, input logic [15:0] d, input logic ordy);
        s_in_valid  = iv;
        s_in_data   = d;
        s_out_ready = ordy;
    endtask

    logic [7:0] q[$];
    logic       iv;
    logic       ordy;
    logic [7:0] rd;
    logic       exp_rdy;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        s_flush = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        sdrive(1'b0, 16'h0000, 1'b0);

        // Reset state
        tick();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk_cnt("rst_count", 0);
        chk("rst_s_out_valid", s_out_valid, 0);
        chk("rst_s_in_ready", s_in_ready, 0);
        reset = 1'b0;
        tick();

        // Unstalled stream 0x01..0x10
        for (int k = 0; k < 24; k++) begin
            drive(k < 16, 8'(k + 1), 1'b1);
            #1;
            if (k < 16) chk("stream_in_ready", in_ready, 1);
            chk("stream_out_valid", out_valid, (k >= 8 && k < 24));
            if (k >= 8) chk("stream_out_data", out_data, k - 7);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("stream_empty", out_valid, 0);
        tick();

        // Fill with consumer stalled
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, (j < 8) ? 8'(8'hA0 + j) : 8'hA8, 1'b0);
            #1;
            chk("fill_in_ready", in_ready, (j < 8));
            chk_cnt("fill_count", (j < 8) ? j : 8);
            if (j >= 8) begin
                chk("fill_out_valid", out_valid, 1);
                chk("fill_out_data", out_data, 8'hA0);
            end
            tick();
        end

        // Drain; 0xA8 and 0xA9 are accepted while draining
        for (int d = 0; d < 11; d++) begin
            drive(d < 2, 8'(8'hA8 + d), 1'b1);
            #1;
            if (d < 2) chk("drain_in_ready", in_ready, 1);
            chk_cnt("drain_count", (d < 2) ? 8 : 10 - d);
            chk("drain_out_valid", out_valid, (d < 10));
            if (d < 10) chk("drain_out_data", out_data, 8'hA0 + d);
            tick();
        end

        // Random traffic against a scoreboard queue
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            rd   = 8'($urandom);
            drive(iv, rd, ordy);
            #1;
            exp_rdy = !(q.size() == 8 && !ordy);
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk_cnt("rnd_count", q.size());
            if (out_valid && ordy) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", out_valid, 0);
                end else begin
                    chk("rnd_out_data", out_data, q[0]);
                    void'(q.pop_front());
                end
            end
            if (iv && exp_rdy) q.push_back(rd);
            tick();
        end
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            #1;
            if (out_valid) begin
                chk("rnd_drain_data", out_data, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        chk("rnd_drain_left", q.size(), 0);
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("rnd_drain_empty", out_valid, 0);
        tick();

        // Flush with three words in flight beats a simultaneous accept
        for (int f = 0; f < 3; f++) begin
            drive(1'b1, 8'(8'h11 * (f + 1)), 1'b0);
            tick();
        end
        drive(1'b1, 8'h55, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1);
        chk_cnt("flush_count_pre", 3);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk_cnt("flush_count", 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("flush_quiet", out_valid, 0);
        end
        tick();

        // Asynchronous reset with five words in flight
        for (int r = 0; r < 9; r++) begin
            drive(r < 5, 8'(8'h61 + r), 1'b0);
            #1;
            if (r == 8) begin
                chk("prerst_out_valid", out_valid, 1);
                chk("prerst_out_data", out_data, 8'h61);
                chk_cnt("prerst_count", 5);
            end
            if (r < 8) tick();
        end
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_in_ready", in_ready, 0);
        chk_cnt("arst_count", 0);
        tick();
        reset = 1'b0;
        drive(1'b1, 8'h3C, 1'b1);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();
        for (int k = 1; k <= 9; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            #1;
            chk("post_rst_out_valid", out_valid, (k == 8));
            if (k == 8) chk("post_rst_out_data", out_data, 8'h3C);
            tick();
        end

        // DEPTH=1 instance: stall holds the word, ready gives full rate
        sdrive(1'b1, 16'hBEEF, 1'b0);
        #1;
        chk("d1_c0_in_ready", s_in_ready, 1);
        chk("d1_c0_out_valid", s_out_valid, 0);
        tick();
        sdrive(1'b1, 16'h1234, 1'b0);
        #1;
        chk("d1_c1_out_data", s_out_data, 16'hBEEF);
        chk("d1_c1_in_ready", s_in_ready, 0);
        tick();
        sdrive(1'b1, 16'h1234, 1'b0);
        #1;
        chk("d1_c2_out_valid", s_out_valid, 1);
        chk("d1_c2_out_data", s_out_data, 16'hBEEF);
        chk("d1_c2_in_ready", s_in_ready, 0);
        tick();
        sdrive(1'b1, 16'h1234, 1'b1);
        #1;
        chk("d1_c3_out_data", s_out_data, 16'hBEEF);
        chk("d1_c3_in_ready", s_in_ready, 1);
        tick();
        sdrive(1'b1, 16'h5678, 1'b0);
        #1;
        chk("d1_c4_out_data", s_out_data, 16'h1234);
        chk("d1_c4_in_ready", s_in_ready, 0);
        tick();
        sdrive(1'b1, 16'h5678, 1'b1);
        #1;
        chk("d1_c5_out_data", s_out_data, 16'h1234);
        chk("d1_c5_in_ready", s_in_ready, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            sdrive(k < 3, 16'(16'hA001 + k), 1'b1);
            #1;
            if (k < 3) chk("d1_run_in_ready", s_in_ready, 1);
            chk("d1_run_out_valid", s_out_valid, (k < 4));
            if (k == 0) chk("d1_run_out_data", s_out_data, 16'h5678);
            else if (k < 4) chk("d1_run_out_data", s_out_data, 16'hA000 + k);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pusher_chain.md
Name: pusher_chain

Overview:
- Parametrised elastic successor to the fixed 8-stage, 8-bit pusher shift chain.
- DEPTH register stages, each WIDTH bits wide, each with its own valid bit.
- valid/ready backpressure: bubbles collapse, so a stalled output does not lose data.
- Sits between byte/word producers and consumers as a delay line or elastic buffer. It also provides a synchronous flush.

Parameters:
- WIDTH, 8, data width in bits per stage (>=1).
- DEPTH, 8, number of pipeline stages (>=1). This is both the maximum occupancy and the unstalled latency.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  word to insert.
- in_ready  output  1  chain can accept a word this cycle.
- out_valid  output  1  stage DEPTH-1 holds a word.
- out_data  output  WIDTH  contents of stage DEPTH-1.
- out_ready  input  1  consumer takes the word this cycle.
- count  output  clog2(DEPTH+1)  occupancy. Present only with PUSHER_CHAIN_COUNT_EN.

Behaviour:
- State: data[i] and v[i] for stages i = 0..DEPTH-1. Stage 0 is the input end; stage DEPTH-1 drives the out_* ports.
- Reset (asynchronous): all v[i]=0 and all data[i]=0.
  - Hence out_valid=0 and out_data=0.
  - count=0.
  - in_ready is forced to 0 while reset is high.
- Advance terms (combinational):
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For i < DEPTH-1: adv[i] = v[i] & (~v[i+1] | adv[i+1]).
  - A stage moves its word forward whenever the next stage is empty or is itself moving.
- in_ready = ~reset & (~v[0] | adv[0]).
- Accept: a word is accepted when in_valid & in_ready. On the edge it is written to data[0] and v[0] is set.
- Stage update on each edge, for i > 0:
  - If adv[i-1]: data[i] <= data[i-1], v[i] <= 1.
  - Else if adv[i]: v[i] <= 0.
  - Otherwise the stage holds.
- Data registers load only when a word moves in. Their value while invalid is don't-care after reset.
- Latency: with out_ready held high, a word accepted in cycle c gives out_valid=1 with that word in cycle c+DEPTH.
- Throughput: one word per cycle when unstalled. Zero-latency pass-through never happens, even with DEPTH=1.
- Ordering: words leave strictly in acceptance order. There is no duplication and no loss under any out_ready pattern.
- Full: all DEPTH valids set with out_ready=0 gives in_ready=0. Accept and emit in the same cycle is allowed when full and out_ready=1.
- Empty: out_valid=0; out_data holds its last value (don't-care).
- Flush (synchronous):
  - All v[i] <= 0 on the edge.
  - Flush beats an accept in the same cycle: the incoming word is dropped, though in_ready still reflects its normal value.
  - A word presented with out_valid&out_ready in the flush cycle counts as delivered.
- Reset mid-operation: all in-flight words are discarded immediately. The first accept is allowed on the first edge after reset deasserts.

Optional Feature:
- PUSHER_CHAIN_COUNT_EN defined:
  - The count port exists and is a registered occupancy.
  - Update rule: +1 on accept, -1 on emit, unchanged when both or neither occur.
  - count <= 0 on flush or reset.
  - Range 0..DEPTH; it must never wrap.
- Not defined: the count port and its register are absent. The rest of the behaviour is identical.

Test Plan:
- WIDTH=8, DEPTH=8, out_ready=1, stream 0x01..0x10 with in_valid=1 -> in_ready stays 1; out_data sequence is 0x01..0x10, first out_valid 8 cycles after first accept, no gaps.
- Fill with out_ready=0, offering 0xA0..0xA9 -> 8 words accepted (0xA0..0xA7); in_ready=0 from the 9th cycle; count=8; then out_ready=1 drains 0xA0..0xA7 in order, and 0xA8/0xA9 follow.
- Random in_valid and out_ready (50% each) for 2000 cycles against a scoreboard queue -> no loss, duplication or reordering; count (when enabled) always equals queue depth and stays <=8.
- 3 words in flight, flush=1 together with in_valid=1 data 0x55 -> next cycle all valids 0, count=0, 0x55 never appears at the output.
- Assert reset asynchronously between clock edges with 5 words in flight -> out_valid=0, out_data=0 and in_ready=0 immediately. After release, a single word 0x3C emerges after 8 cycles.
- DEPTH=1, WIDTH=16, alternating out_ready -> full throughput when out_ready=1. When out_ready=0 the held word 0xBEEF stays stable and in_ready=0.
